// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared constants and helpers for the FFT output reorder stage.
//   N_LOG2   : log2 of the frame length
//   N        : samples per frame
//   DATA_W   : width of each of the real / imaginary parts
//   LAST_IDX : index of the final sample in a frame (N-1), counter-width
//   bitrev() : reverses the N_LOG2-bit index (the pipeline's output order)
package fft_pkg;

  localparam int N_LOG2 = 5;
  localparam int N      = 2 ** N_LOG2;
  localparam int DATA_W = 32;

  localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] idx);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int b = 0; b < N_LOG2; b++) begin
      r[b] = idx[N_LOG2-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram
//   Two-bank sample store (2 x N words of 2*DATA_W bits) for the reorder stage.
//   One bank fills while the other drains; bank select is the word address MSB.
//   Contents are never cleared, so there is no reset.
// Ports
//   clk      in  clock, write on posedge
//   we       in  write enable
//   wr_bank  in  bank being written
//   wr_addr  in  word index inside the write bank
//   wr_data  in  {re, im}
//   rd_bank  in  bank being read
//   rd_addr  in  word index inside the read bank
//   rd_data  out {re, im}, asynchronous read
import fft_pkg::*;

module fft_pingpong_ram (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  wr_bank,
  input  logic [N_LOG2-1:0]     wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic                  rd_bank,
  input  logic [N_LOG2-1:0]     rd_addr,
  output logic [2*DATA_W-1:0]   rd_data
);

  logic [2*DATA_W-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
//   Output reorder stage for the 32-point radix-2 SDF FFT. Samples arrive in
//   bit-reversed index order and are written to the fill bank at bitrev(count);
//   the drain bank is then read out sequentially, giving natural bin order.
//   A bank is handed from writer to reader through its bank_full flag.
// Ports
//   clk         in   clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   din_re/im   in   input sample (bit-reversed order)
//   din_valid   in   input sample present
//   din_ready   out  stage can accept (fill bank not full)
//   dout_re/im  out  output sample (natural order), registered
//   dout_valid  out  dout_* holds a valid sample
//   dout_ready  in   consumer accepts
//   dout_sof    out  sample is bin 0
//   dout_eof    out  sample is bin N-1
import fft_pkg::*;

module fft_bitrev_reorder (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_re,
  input  logic [DATA_W-1:0] din_im,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout_re,
  output logic [DATA_W-1:0] dout_im,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sof,
  output logic              dout_eof
);

  logic [N_LOG2-1:0]   wr_cnt;
  logic [N_LOG2-1:0]   rd_cnt;
  logic                wr_bank;
  logic                rd_bank;
  logic [1:0]          bank_full;
  logic [1:0]          bank_full_nxt;
  logic                wr_fire;
  logic                wr_last;
  logic                advance;
  logic                rd_fire;
  logic                rd_last;
  logic [2*DATA_W-1:0] rd_data;

  assign din_ready = !bank_full[wr_bank];
  assign wr_fire   = din_valid && din_ready;
  assign wr_last   = (wr_cnt == LAST_IDX);

  assign advance   = !dout_valid || dout_ready;
  assign rd_fire   = advance && bank_full[rd_bank];
  assign rd_last   = (rd_cnt == LAST_IDX);

  fft_pingpong_ram u_ram (
    .clk     (clk),
    .we      (wr_fire),
    .wr_bank (wr_bank),
    .wr_addr (bitrev(wr_cnt)),
    .wr_data ({din_re, din_im}),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  // Writer only sets a flag that is clear and the reader only clears one that
  // is set, so when both fire in one cycle they address different banks.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_fire && wr_last) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (rd_fire && rd_last) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
      // Counters wrap naturally at N, which returns them to 0 after the last sample.
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_last) begin
          rd_bank <= ~rd_bank;
        end
      end
    end
  end

  // Output register: loads only on advance, so a stalled sample holds stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_re    <= '0;
      dout_im    <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
    end else if (advance) begin
      if (bank_full[rd_bank]) begin
        dout_re    <= rd_data[2*DATA_W-1:DATA_W];
        dout_im    <= rd_data[DATA_W-1:0];
        dout_valid <= 1'b1;
        dout_sof   <= (rd_cnt == '0);
        dout_eof   <= rd_last;
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
